product_accumulator: RTL and testbench

Downstream consumer of the sequential tree multiplier's 64-bit product stream. It sums a frame of unsigned products, for dot-product or MAC-style use, into a wide accumulator. It presents the frame total on a valid/ready output port. Frames are delimited by an input last flag or by a maximum term count.

---
 rtl/product_acc_pkg.sv | 19 +
 rtl/acc_sat_adder.sv | 24 ++
 rtl/product_accumulator.sv | 89 ++++++++
 tb/tb_product_accumulator.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/product_acc_pkg.sv
// Shared types and helpers for the product accumulator.
// PRODUCT_ACC_SAT_EN (see acc_sat_adder) selects saturating instead of wrapping sums.
package product_acc_pkg;

  localparam int PRODUCT_W = 64;
  // Upper bound on any accumulator width; callers cast the result down to ACC_W.
  localparam int ACC_W_MAX = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

  function automatic logic [ACC_W_MAX-1:0] zext_product(input logic [PRODUCT_W-1:0] p);
    return {{(ACC_W_MAX - PRODUCT_W){1'b0}}, p};
  endfunction

endpackage

// File: rtl/acc_sat_adder.sv
// ACC_W-bit unsigned adder with carry out.
// With PRODUCT_ACC_SAT_EN defined the sum clamps to all ones on carry; otherwise it wraps.
module acc_sat_adder #(
  parameter int ACC_W = 72
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] raw;

  assign raw   = {1'b0, a} + {1'b0, b};
  assign carry = raw[ACC_W];

`ifdef PRODUCT_ACC_SAT_EN
  // Once clamped, any later non-zero term carries again, so the clamp persists for the frame.
  assign sum = carry ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
  assign sum = raw[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums a frame of 64-bit unsigned products and presents the total on a valid/ready port.
// Build option PRODUCT_ACC_SAT_EN makes the sum saturate instead of wrap.
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter  int ACC_W     = 72,
  parameter  int MAX_TERMS = 256,
  localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PRODUCT_W-1:0] in_product,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_sum,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_overflow,
  output logic                 out_truncated
);

  // Handshakes: a beat moves when valid && ready are both high at posedge clk.
  // in_ready depends only on registered state and rst; out_valid only on registered state.

  acc_state_t       state;
  logic [ACC_W-1:0] sum_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic             trunc_q;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic [CNT_W-1:0] count_next;
  logic             accept;
  logic             close;

  assign prod_ext   = ACC_W'(zext_product(in_product));
  assign in_ready   = (state != HOLD) && rst;
  assign accept     = in_valid && in_ready;
  assign add_a      = (state == ACCUM) ? sum_q : '0;
  assign count_next = (state == ACCUM) ? count_q + CNT_W'(1) : CNT_W'(1);
  assign close      = in_last || (count_next == CNT_W'(MAX_TERMS));

  acc_sat_adder #(
    .ACC_W(ACC_W)
  ) u_adder (
    .a    (add_a),
    .b    (prod_ext),
    .sum  (add_sum),
    .carry(add_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            sum_q   <= add_sum;
            count_q <= count_next;
            ovf_q   <= ((state == ACCUM) && ovf_q) || add_carry;
            trunc_q <= close && !in_last;
            state   <= close ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid     = (state == HOLD);
  assign out_sum       = sum_q;
  assign out_count     = count_q;
  assign out_overflow  = ovf_q;
  assign out_truncated = trunc_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator (ACC_W=64, MAX_TERMS=4) with a frame scoreboard.
module tb_product_accumulator;

  localparam int ACC_W     = 64;
  localparam int MAX_TERMS = 4;
  localparam int CNT_W     = 3;
  localparam int EXP_W     = ACC_W + CNT_W + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_product;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_overflow;
  logic             out_truncated;

  int tests = 0;
  int fails = 0;
  logic [EXP_W-1:0] exp_q[$];

  product_accumulator #(
    .ACC_W    (ACC_W),
    .MAX_TERMS(MAX_TERMS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_product   (in_product),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_count    (out_count),
    .out_overflow (out_overflow),
    .out_truncated(out_truncated)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic void expect_frame(input logic [63:0] s, input logic [2:0] c,
                                       input logic o, input logic t);
    exp_q.push_back({s, c, o, t});
  endfunction

  // Driver tasks
  task automatic drive_beat(input logic [63:0] p, input logic last);
    @(negedge clk);
    in_valid   = 1'b1;
    in_product = p;
    in_last    = last;
  endtask

  task automatic wait_accept();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 1, 0);
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] p, input logic last);
    drive_beat(p, last);
    wait_accept();
  endtask

  // Monitor: compare every output handshake against the expected queue
  initial begin
    logic [EXP_W-1:0] exp;
    forever begin
      @(negedge clk);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got sum=%0h count=%0d, required no frame",
                   out_sum, out_count);
        end else begin
          exp = exp_q.pop_front();
          check("frame_result", {out_sum, out_count, out_overflow, out_truncated}, exp);
        end
      end
    end
  end

  initial begin
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_product = '0;
    in_last    = 1'b0;
    out_ready  = 1'b0;

    // 1. Reset and idle
    repeat (2) begin
      @(negedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sum", out_sum, 0);
      check("rst_out_count", out_count, 0);
      check("rst_in_ready", in_ready, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("idle_in_ready", in_ready, 1);

    // 2. Three-term frame with back-pressure
    send_beat(64'd10, 1'b0);
    send_beat(64'd20, 1'b0);
    expect_frame(64'd60, 3'd3, 1'b0, 1'b0);
    send_beat(64'd30, 1'b1);
    check("close_latency_valid", out_valid, 1);
    repeat (3) begin
      check("hold_in_ready", in_ready, 0);
      check("hold_sum_stable", out_sum, 60);
      check("hold_valid", out_valid, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);

    // 3. MAX_TERMS truncation; fifth beat waits for the output handshake
    out_ready = 1'b0;
    repeat (3) send_beat(64'd1, 1'b0);
    expect_frame(64'd4, 3'd4, 1'b0, 1'b1);
    send_beat(64'd1, 1'b0);
    check("trunc_close_valid", out_valid, 1);
    drive_beat(64'd1, 1'b0);
    check("trunc_blocked_ready", in_ready, 0);
    check("trunc_blocked_count", out_count, 4);
    @(negedge clk);
    check("trunc_blocked_ready2", in_ready, 0);
    check("trunc_blocked_count2", out_count, 4);
    out_ready = 1'b1;
    wait_accept();
    check("new_frame_open_valid", out_valid, 0);
    check("new_frame_count", out_count, 1);
    expect_frame(64'd7, 3'd2, 1'b0, 1'b0);
    send_beat(64'd6, 1'b1);

    // 4. Overflow: wrap by default, clamp with saturation
`ifdef PRODUCT_ACC_SAT_EN
    expect_frame(64'hFFFF_FFFF_FFFF_FFFF, 3'd2, 1'b1, 1'b0);
`else
    expect_frame(64'd1, 3'd2, 1'b1, 1'b0);
`endif
    send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_beat(64'd2, 1'b1);

    // 5. Reset mid-frame discards the partial frame
    send_beat(64'd5, 1'b0);
    send_beat(64'd7, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    check("midrst_out_count", out_count, 0);
    check("midrst_out_valid", out_valid, 0);
    rst = 1'b1;
    expect_frame(64'd9, 3'd1, 1'b0, 1'b0);
    send_beat(64'd9, 1'b1);

    // 6. Back-to-back single-beat frames
    expect_frame(64'd3, 3'd1, 1'b0, 1'b0);
    send_beat(64'd3, 1'b1);
    expect_frame(64'd4, 3'd1, 1'b0, 1'b0);
    send_beat(64'd4, 1'b1);
    expect_frame(64'd5, 3'd1, 1'b0, 1'b0);
    send_beat(64'd5, 1'b1);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
